// File: rtl/fsm_share_pkg.sv
// Shared definitions for the round-robin FSM-sharing arbiter:
// controller state encoding and default channel/symbol/state widths.
package fsm_share_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_YW   = 2;
    localparam int DEF_SW   = 4;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/fsm_share_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, wrapping modulo NREQ, and returns it one-hot and as an index.
module rr_pick
    import fsm_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan from ptr upward with wrap; first hit wins.
    always_comb begin
        int j;
        // NOTE: every output gets a default before the scan so no path through the loop leaves one unassigned (no latch).
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fsm_share_arbiter.sv
// Round-robin controller sharing one FSM among NREQ requesters: grant one
// request, step the FSM once with its symbol, return the new state tagged
// with the requester id, then advance the round-robin pointer.
module fsm_share_arbiter
    import fsm_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int YW   = DEF_YW,
    parameter int SW   = DEF_SW,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*YW-1:0] req_y,
    output logic [NREQ-1:0]    req_ready,
    output logic [YW-1:0]      fsm_y,
    output logic               fsm_step,
    input  logic [SW-1:0]      fsm_state,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [SW-1:0]      rsp_state,
    output logic               busy
);

    ctrl_state_t     state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic [YW-1:0]   y_q;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state and output decode; outputs are zero outside their own state.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        fsm_y     = '0;
        fsm_step  = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_state = '0;
        unique case (state_q)
            ARB: begin
                // A request held across reset must not see an accept strobe.
                if (rst_n && pick_any) begin
                    req_ready = pick_grant;
                    state_d   = STEP;
                end
            end
            STEP: begin
                fsm_step = 1'b1;
                fsm_y    = y_q;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_state = fsm_state;
                if (rsp_ready) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Capture the winning request's symbol and id at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= '0;
            id_q <= '0;
        end else if (state_q == ARB && pick_any) begin
            y_q  <= req_y[int'(pick_idx)*YW +: YW];
            id_q <= pick_idx;
        end
    end

    // Round-robin pointer moves past the answered requester on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (state_q == RESP && rsp_ready) begin
            ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    assign busy = (state_q != ARB);

endmodule

// File: tb/tb_fsm_share_arbiter.sv
// Self-checking bench for fsm_share_arbiter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_fsm_share_arbiter;

    localparam int NREQ = 4;
    localparam int YW   = 2;
    localparam int SW   = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*YW-1:0] req_y = '0;
    logic [NREQ-1:0]    req_ready;
    logic [YW-1:0]      fsm_y;
    logic               fsm_step;
    logic [SW-1:0]      fsm_state;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [IDW-1:0]     rsp_id;
    logic [SW-1:0]      rsp_state;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsm_share_arbiter #(
        .NREQ (NREQ),
        .YW   (YW),
        .SW   (SW),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_y     (req_y),
        .req_ready (req_ready),
        .fsm_y     (fsm_y),
        .fsm_step  (fsm_step),
        .fsm_state (fsm_state),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_state (rsp_state),
        .busy      (busy)
    );

    // Stand-in for the shared FSM: any deterministic next-state rule will do.
    function automatic logic [SW-1:0] fsm_next(input logic [SW-1:0] s, input logic [YW-1:0] y);
        return SW'((int'(s) * 5 + int'(y) + 3) % 16);
    endfunction

    // Environment FSM, gated by fsm_step and sharing rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_state <= '0;
        else if (fsm_step) fsm_state <= fsm_next(fsm_state, fsm_y);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 stepping, 2 answering.
    int              m_phase;
    int              m_ptr;
    int              m_id;
    logic [YW-1:0]   m_y;
    logic [SW-1:0]   m_s;

    // Outputs sampled at the most recent falling edge.
    logic [NREQ-1:0] sn_ready;
    logic            sn_step;
    logic [YW-1:0]   sn_fy;
    logic            sn_rv;
    logic [IDW-1:0]  sn_id;
    logic [SW-1:0]   sn_rs;
    logic            sn_busy;

    function automatic int rr_winner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_y     = '0;
        m_s     = '0;
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] e_ready;
        int w;
        e_ready = '0;
        w = rr_winner(req_valid, m_ptr);
        if (m_phase == 0 && w >= 0) e_ready[w] = 1'b1;
        check("req_ready", req_ready, e_ready);
        check("fsm_step",  fsm_step,  m_phase == 1);
        check("fsm_y",     fsm_y,     (m_phase == 1) ? m_y : '0);
        check("rsp_valid", rsp_valid, m_phase == 2);
        check("rsp_id",    rsp_id,    (m_phase == 2) ? IDW'(m_id) : '0);
        check("rsp_state", rsp_state, (m_phase == 2) ? m_s : '0);
        check("busy",      busy,      m_phase != 0);
        sn_ready = req_ready;
        sn_step  = fsm_step;
        sn_fy    = fsm_y;
        sn_rv    = rsp_valid;
        sn_id    = rsp_id;
        sn_rs    = rsp_state;
        sn_busy  = busy;
    endtask

    task automatic model_advance();
        int w;
        case (m_phase)
            0: begin
                w = rr_winner(req_valid, m_ptr);
                if (w >= 0) begin
                    m_id    = w;
                    m_y     = req_y[w*YW +: YW];
                    m_phase = 1;
                end
            end
            1: begin
                m_s     = fsm_next(m_s, m_y);
                m_phase = 2;
            end
            default: begin
                if (rsp_ready) begin
                    m_ptr   = (m_id + 1) % NREQ;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic run_cycle(input logic [NREQ-1:0] v, input logic [NREQ*YW-1:0] y, input logic rdy);
        req_valid = v;
        req_y     = y;
        rsp_ready = rdy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, '0);
        check("rst_fsm_step",  fsm_step,  1'b0);
        check("rst_fsm_y",     fsm_y,     '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id",    rsp_id,    '0);
        check("rst_rsp_state", rsp_state, '0);
        check("rst_busy",      busy,      1'b0);
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int grants[$];

        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset: nothing happens.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle('0, '0, 1'b0);
            cnt += int'(sn_step) + int'(sn_busy);
        end
        check("idle_activity", cnt, 0);

        // Single request from channel 2 with Y=01.
        run_cycle(4'b0100, 8'h10, 1'b1);
        check("single_grant", sn_ready, 4'b0100);
        run_cycle('0, '0, 1'b1);
        check("single_step", sn_step, 1'b1);
        check("single_fsm_y", sn_fy, 2'b01);
        run_cycle('0, '0, 1'b1);
        check("single_rsp_valid", sn_rv, 1'b1);
        check("single_rsp_id", sn_id, 2);
        check("single_rsp_state", sn_rs, 4'd4);
        run_cycle('0, '0, 1'b1);

        // Pointer wrap: grant 3 with ptr=3, then 0.
        run_cycle(4'b1000, 8'hC0, 1'b1);
        check("wrap_grant3", sn_ready, 4'b1000);
        run_cycle('0, '0, 1'b1);
        run_cycle('0, '0, 1'b1);
        run_cycle(4'b0001, 8'h01, 1'b1);
        check("wrap_grant0", sn_ready, 4'b0001);
        run_cycle('0, '0, 1'b1);
        run_cycle('0, '0, 1'b1);

        // Backpressure: 5 cycles of rsp_ready low with every requester waiting.
        run_cycle(4'b0010, 8'h0C, 1'b1);
        check("bp_grant", sn_ready, 4'b0010);
        run_cycle('0, '0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(4'b1111, 8'hE4, 1'b0);
            check("bp_rsp_valid", sn_rv, 1'b1);
            check("bp_rsp_id", sn_id, 1);
            cnt += int'(sn_step) + int'(sn_ready != '0);
        end
        check("bp_no_step_no_grant", cnt, 0);
        run_cycle(4'b0000, 8'h00, 1'b1);
        check("bp_complete_valid", sn_rv, 1'b1);
        run_cycle(4'b0000, 8'h00, 1'b1);
        check("bp_back_idle", sn_busy, 1'b0);

        // Reset during STEP, request still held: aborted, then answered from reset state.
        run_cycle(4'b0001, 8'h02, 1'b1);
        check("mid_grant", sn_ready, 4'b0001);
        check("mid_in_step", fsm_step, 1'b1);
        do_reset();
        run_cycle('0, '0, 1'b1);
        check("mid_no_response", sn_rv, 1'b0);
        run_cycle(4'b0001, 8'h02, 1'b1);
        run_cycle('0, '0, 1'b1);
        run_cycle('0, '0, 1'b1);
        check("mid_rsp_id", sn_id, 0);
        check("mid_rsp_state", sn_rs, 4'd5);
        run_cycle('0, '0, 1'b1);

        // All four valid from a fresh pointer: strict round-robin order.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            run_cycle(4'b1111, 8'hE4, 1'b1);
            if (sn_ready != '0) grants.push_back(onehot_idx(sn_ready));
        end
        check("rr_grant_count", grants.size(), 8);
        for (int i = 0; i < grants.size() && i < 8; i++) begin
            check("rr_order", grants[i], i % NREQ);
        end
        run_cycle('0, '0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            run_cycle(NREQ'($urandom), (NREQ*YW)'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
